// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Optional statistics counters are enabled with FETCH_STATS_EN.
package fetch_pkg;

  localparam int unsigned FETCH_WIDTH = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    FULL
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_WIDTH-1:0] pc;
    logic [FETCH_WIDTH-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch stage.
// master = fetch_unit side, slave = memory/decode environment side.
interface fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic [WIDTH-1:0] imem_rdata;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_instr;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr,
    output imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with wrap-around pointers.
// Flush takes priority over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a 1-cycle instruction memory,
// buffers words in a prefetch FIFO. FETCH_STATS_EN adds push/squash counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = FETCH_WIDTH,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_squashed
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] target;
  logic             req, push, pop, flush, out_valid;
  logic [CW-1:0]    count, count_nxt;
  fetch_entry_t     push_entry, head;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (count)
  );

  // In-flight reads reserve a FIFO slot so a response always has room.
  always_comb begin
    target           = bus.redirect_pc & ~WIDTH'(INSTR_BYTES - 1);
    out_valid        = (count != '0);
    req              = (state_q == FETCH) && ((count + CW'(inflight_q)) < CW'(DEPTH)) && !bus.redirect;
    pop              = out_valid && bus.out_ready;
    push             = inflight_q && !bus.redirect;
    flush            = bus.redirect;
    push_entry.pc    = FETCH_WIDTH'(req_pc_q);
    push_entry.instr = FETCH_WIDTH'(bus.imem_rdata);
    fetch_pc_d       = fetch_pc_q;
    if (bus.redirect) begin
      fetch_pc_d = target;
    end else if (req) begin
      fetch_pc_d = fetch_pc_q + WIDTH'(INSTR_BYTES);
    end
    req_pc_d   = req ? fetch_pc_q : req_pc_q;
    inflight_d = req;
    count_nxt  = flush ? '0 : count + CW'(push) - CW'(pop);
    state_d    = state_q;
    if (bus.redirect || state_q == BOOT) begin
      state_d = FETCH;
    end else begin
      state_d = ((count_nxt + CW'(inflight_d)) == CW'(DEPTH)) ? FULL : FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_pc    = out_valid ? WIDTH'(head.pc) : '0;
  assign bus.out_instr = out_valid ? WIDTH'(head.instr) : '0;

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, fetched_d;
  logic [31:0] squashed_q, squashed_d;

  // A pop coinciding with a redirect is a real consume, not a squash.
  always_comb begin
    fetched_d  = push ? sat_add32(fetched_q, 32'd1) : fetched_q;
    squashed_d = squashed_q;
    if (flush) begin
      squashed_d = sat_add32(squashed_q, 32'(count - CW'(pop)) + 32'(inflight_q));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      fetched_q  <= fetched_d;
      squashed_q <= squashed_d;
    end
  end

  assign stat_fetched  = fetched_q;
  assign stat_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// ready/redirect traffic checked against a queue-based reference model.
module tb_fetch_unit;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  fetch_unit_if #(.WIDTH(32)) bus ();
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_squashed;
`endif

  fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_squashed(stat_squashed)
`endif
  );

  always #5 clk = ~clk;

  bit mem_const;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return mem_const ? 32'h0000_0013 : ((a * 32'h9E37_79B1) ^ 32'h1357_9BDF);
  endfunction

  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= mem_fn(bus.imem_addr);
  end

  // Reference model: every issued request becomes an entry visible two
  // cycles later; the queue holds buffered plus in-flight words in order.
  typedef struct {
    logic [31:0] pc;
    int          vis;
  } pend_t;

  pend_t       pend[$];
  int          cyc;
  bit          boot;
  logic [31:0] next_req;
  int unsigned m_fetched, m_squashed;
  int          checks = 0;
  int          failures = 0;
  int          first_valid_cyc;
  int          obs_acc, obs_req;
  logic        s_valid, s_req;
  logic [31:0] s_addr, s_pc;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    boot       = 1'b1;
    next_req   = RST_PC;
    cyc        = 0;
    m_fetched  = 0;
    m_squashed = 0;
  endtask

  // Called at a falling edge; drives inputs, checks, advances the model.
  task automatic step(input bit ready, input bit redir, input logic [31:0] tgt);
    bit ev, er;
    bus.out_ready   = ready;
    bus.redirect    = redir;
    bus.redirect_pc = tgt;
    #1;
    ev = (pend.size() > 0) && (pend[0].vis <= cyc);
    er = !boot && (pend.size() < DEPTH) && !redir;
    s_valid = bus.out_valid;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_pc    = bus.out_pc;
    chk_eq("out_valid", 32'(s_valid), 32'(ev));
    chk_eq("imem_req", 32'(s_req), 32'(er));
    if (er) chk_eq("imem_addr", s_addr, next_req);
    if (ev) begin
      chk_eq("out_pc", s_pc, pend[0].pc);
      chk_eq("out_instr", bus.out_instr, mem_fn(pend[0].pc));
    end
`ifdef FETCH_STATS_EN
    chk_eq("stat_fetched", stat_fetched, 32'(m_fetched));
    chk_eq("stat_squashed", stat_squashed, 32'(m_squashed));
`endif
    if (s_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (s_valid && ready) obs_acc++;
    if (s_req) obs_req++;
    if (ev && ready) void'(pend.pop_front());
    if (redir) begin
      m_squashed += pend.size();
      pend.delete();
      next_req = tgt & 32'hFFFF_FFFC;
    end else begin
      foreach (pend[i]) if (pend[i].vis == cyc + 1) m_fetched++;
      if (er) begin
        pend.push_back('{pc: next_req, vis: cyc + 2});
        next_req += 32'd4;
      end
    end
    boot = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset(input bit cmode);
    #1;
    rst          = 1'b0;
    bus.redirect = 1'b0;
    bus.out_ready = 1'b0;
    mem_const    = cmode;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] t;
    rst             = 1'b0;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    mem_const       = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk_eq("reset_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("reset_req", 32'(bus.imem_req), 32'd0);
    chk_eq("reset_pc", bus.out_pc, 32'd0);
    chk_eq("reset_instr", bus.out_instr, 32'd0);
    rst = 1'b1;
    model_reset();

    // Streaming from reset: first word at cycle 3, then one per cycle.
    first_valid_cyc = -1;
    obs_acc = 0;
    repeat (13) step(1'b1, 1'b0, '0);
    chk_eq("first_valid_cycle", 32'(first_valid_cyc), 32'd3);
    chk_eq("throughput", 32'(obs_acc), 32'd10);

    // Stall fills exactly DEPTH entries, then drains in order.
    do_reset(1'b1);
    obs_req = 0;
    repeat (10) step(1'b0, 1'b0, '0);
    chk_eq("stall_reqs", 32'(obs_req), 32'(DEPTH));
    chk_eq("full_req", 32'(s_req), 32'd0);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, '0);
      chk_eq("drain_valid", 32'(s_valid), 32'd1);
      chk_eq("drain_pc", s_pc, 32'(i * 4));
    end

    // Redirect with two buffered entries and one read in flight.
    do_reset(1'b1);
    repeat (4) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h100);
    step(1'b1, 1'b0, '0);
    chk_eq("redir_valid_r1", 32'(s_valid), 32'd0);
    chk_eq("redir_addr", s_addr, 32'h100);
`ifdef FETCH_STATS_EN
    chk_eq("redir_squashed", stat_squashed, 32'd3);
    chk_eq("redir_fetched", stat_fetched, 32'd2);
`endif
    step(1'b1, 1'b0, '0);
    chk_eq("redir_valid_r2", 32'(s_valid), 32'd0);
    step(1'b1, 1'b0, '0);
    chk_eq("redir_valid_r3", 32'(s_valid), 32'd1);
    chk_eq("redir_pc", s_pc, 32'h100);

    // Unaligned target and address wrap.
    step(1'b1, 1'b1, 32'h203);
    step(1'b1, 1'b0, '0);
    chk_eq("align_addr", s_addr, 32'h200);
    step(1'b1, 1'b1, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, '0);
    chk_eq("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, '0);
    chk_eq("wrap_addr1", s_addr, 32'h0);
    repeat (4) step(1'b1, 1'b0, '0);

    // Asynchronous reset mid-stream.
    #1;
    chk_eq("pre_reset_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b0;
    mem_const = 1'b0;
    #1;
    chk_eq("async_valid", 32'(bus.out_valid), 32'd0);
    chk_eq("async_req", 32'(bus.imem_req), 32'd0);
    chk_eq("async_pc", bus.out_pc, 32'd0);
    chk_eq("async_instr", bus.out_instr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(1'b1, 1'b0, '0);
    chk_eq("boot_req", 32'(s_req), 32'd0);
    step(1'b1, 1'b0, '0);
    chk_eq("restart_addr", s_addr, RST_PC);

    // Randomized ready/redirect traffic.
    repeat (400) begin
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
      step($urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0, t);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
